// File: rtl/us_delay_timer.sv
// ---------------------------------------------------------------------------
// us_delay_timer
//
// Programmable microsecond delay / period timer in the clk_100m domain.
// The 1 MHz timebase strobe tick_1us is used as a clock enable, so the whole
// block runs on clk_100m and no derived clock is needed.
//
// A one-cycle start latches duration and periodic. The timer then arms and
// waits for the next tick before it counts down in whole microseconds.
// It pulses done at each expiry. A one-shot returns to idle after its
// expiry. A periodic timer reloads and keeps running.
//
// Ports:
//   clk_100m   in   100 MHz system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   tick_1us   in   one-cycle 1 us strobe (clock enable)
//   start      in   one-cycle request, samples duration/periodic
//   periodic   in   1 = auto-reload, 0 = one-shot
//   duration   in   interval in microseconds (0 = immediate done)
//   abort      in   cancels any activity, no done generated
//   busy       out  high while armed or running
//   done       out  one-cycle pulse per expiry
//   remaining  out  microseconds left in the current interval
// ---------------------------------------------------------------------------
module us_delay_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk_100m,
  input  logic             rst_n,
  input  logic             tick_1us,
  input  logic             start,
  input  logic             periodic,
  input  logic [CNT_W-1:0] duration,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;
  logic             busy_q;

  // Next-state logic. Priority is abort, then start, then tick.
  // ARM consumes the first tick after start without decrementing, which
  // aligns the countdown to the tick grid. A zero-length start skips the
  // busy phase entirely and pulses done on the next cycle.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    reload_d    = reload_q;
    periodic_d  = periodic_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = IDLE;
      remaining_d = '0;
    end else if (start) begin
      reload_d   = duration;
      periodic_d = periodic;
      if (duration == '0) begin
        done_d      = 1'b1;
        state_d     = IDLE;
        remaining_d = '0;
      end else begin
        remaining_d = duration;
        state_d     = ARM;
      end
    end else if (tick_1us) begin
      case (state_q)
        ARM: begin
          state_d = RUN;
        end
        RUN: begin
          if (remaining_q > CNT_W'(1)) begin
            remaining_d = remaining_q - CNT_W'(1);
          end else if (remaining_q == CNT_W'(1)) begin
            done_d = 1'b1;
            if (periodic_q) begin
              // Reload goes straight back into RUN so the period stays exact.
              remaining_d = reload_q;
            end else begin
              remaining_d = '0;
              state_d     = IDLE;
            end
          end else begin
            // Cannot occur in normal operation. Park safely instead of wrapping.
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and output registers. busy is registered from the next state, so
  // it rises in the cycle after start and always matches the stored state.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      reload_q    <= '0;
      periodic_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      reload_q    <= reload_d;
      periodic_q  <= periodic_d;
      done_q      <= done_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule
